// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C line constants and intended-bit helper
package i2c_pkg;

  localparam logic SDA_RELEASE = 1'b1;
  localparam logic MODE_WRITE  = 1'b0;
  localparam logic MODE_READ   = 1'b1;
  localparam logic SEL_SSA     = 1'b0;
  localparam logic SEL_SHIFT   = 1'b1;
  localparam int   SYNC_STAGES = 2;

  // Level the master wants on the line; read mode always releases.
  function automatic logic intendedBit(input logic readOrWrite,
                                       input logic select,
                                       input logic startStopAck,
                                       input logic shiftOut);
    if (readOrWrite != MODE_WRITE) return SDA_RELEASE;
    return (select == SEL_SHIFT) ? shiftOut : startStopAck;
  endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// rtl/i2c_sync_filter.sv - line synchronizer with optional stability filter (shared by SDA and SCL)
module i2c_sync_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic syncOut,
  output logic filtOut
);

  logic [SYNC_STAGES-1:0] syncReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) syncReg <= {SYNC_STAGES{SDA_RELEASE}};
    else        syncReg <= {syncReg[SYNC_STAGES-2:0], din};
  end

  assign syncOut = syncReg[SYNC_STAGES-1];

  // FILTER_LEN of 0 means a plain synchronizer with no counter at all.
  generate
    if (FILTER_LEN == 0) begin : gBypass
      assign filtOut = syncOut;
    end else begin : gFilter
      localparam logic [3:0] LAST_RUN = 4'(FILTER_LEN - 1);
      logic [3:0] runLen;
      logic       level;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          runLen <= '0;
          level  <= SDA_RELEASE;
        end else if (syncOut == level) begin
          runLen <= '0;
        end else if (runLen == LAST_RUN) begin
          level  <= syncOut;
          runLen <= '0;
        end else begin
          runLen <= runLen + 4'd1;
        end
      end

      assign filtOut = level;
    end
  endgenerate

endmodule

// File: rtl/i2c_sda_module.sv
// rtl/i2c_sda_module.sv - SDA open-drain front end with arbitration-loss detect
// Optional stability filter enabled by defining I2C_SDA_FILTER_EN.
module i2c_sda_module
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ReadorWrite,
  input  logic Select,
  input  logic StartStopAck,
  input  logic ShiftOut,
  output logic ShiftIn,
  output logic ArbLost,
  inout  wire  SDA
);

`ifdef I2C_SDA_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  localparam int FILT_STAGES = FILTER_ON ? FILTER_LEN : 0;
  localparam int ALIGN_DEPTH = SYNC_STAGES + FILT_STAGES;

  logic                   drv_bit;
  logic                   sda_s;
  logic                   drv_aligned;
  logic                   busSeen;
  logic [ALIGN_DEPTH-1:0] alignPipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drv_bit <= SDA_RELEASE;
    else        drv_bit <= intendedBit(ReadorWrite, Select, StartStopAck, ShiftOut);
  end

  // Open drain: only ever pull low, the external pull-up supplies the 1.
  assign SDA = (drv_bit == SDA_RELEASE) ? 1'bz : 1'b0;

  i2c_sync_filter #(
    .FILTER_LEN(FILT_STAGES)
  ) uSyncFilter (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (SDA),
    .syncOut (sda_s),
    .filtOut (ShiftIn)
  );

  // Delay our own drive by the pin-to-ShiftIn latency so both are compared in step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alignPipe <= {ALIGN_DEPTH{SDA_RELEASE}};
    else        alignPipe <= {alignPipe[ALIGN_DEPTH-2:0], drv_bit};
  end

  assign drv_aligned = alignPipe[ALIGN_DEPTH-1];
  assign busSeen     = FILTER_ON ? ShiftIn : sda_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ArbLost <= 1'b0;
    else if (ReadorWrite == MODE_READ)         ArbLost <= 1'b0;
    else if (drv_aligned && !busSeen)          ArbLost <= 1'b1;
  end

endmodule

// File: tb/tb_i2c_sda_module.sv
// tb/tb_i2c_sda_module.sv - directed self-checking bench for i2c_sda_module
module tb_i2c_sda_module;

`ifdef I2C_SDA_FILTER_EN
  localparam int FLT = 3;
`else
  localparam int FLT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rw = 1'b1;
  logic sel = 1'b1;
  logic ssa = 1'b1;
  logic so = 1'b0;
  logic extLow = 1'b0;
  logic shiftIn;
  logic arbLost;
  wire  sdaLine;

  int total = 0;
  int bad = 0;

  pullup (sdaLine);
  assign sdaLine = extLow ? 1'b0 : 1'bz;

  i2c_sda_module #(
    .FILTER_LEN(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ReadorWrite  (rw),
    .Select       (sel),
    .StartStopAck (ssa),
    .ShiftOut     (so),
    .ShiftIn      (shiftIn),
    .ArbLost      (arbLost),
    .SDA          (sdaLine)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkVal("rstSda", sdaLine, 1'b1);
    checkVal("rstShiftIn", shiftIn, 1'b1);
    checkVal("rstArb", arbLost, 1'b0);
    cyc(2);
    rst_n = 1'b1;

    // read mode keeps the line released
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checkVal($sformatf("rdSda%0d", i), sdaLine, 1'b1);
      checkVal($sformatf("rdShiftIn%0d", i), shiftIn, 1'b1);
      checkVal($sformatf("rdArb%0d", i), arbLost, 1'b0);
    end
    sel = 1'b0;
    ssa = 1'b0;
    cyc(2);
    checkVal("rdSsaIgnored", sdaLine, 1'b1);

    // start/stop/ack source
    rw = 1'b0;
    sel = 1'b0;
    ssa = 1'b1;
    cyc(3 + FLT);
    ssa = 1'b0;
    for (int i = 1; i <= 4 + FLT; i++) begin
      cyc(1);
      if (i == 1) checkVal("ssaLowSda", sdaLine, 1'b0);
      checkVal($sformatf("ssaLowShiftIn%0d", i), shiftIn, (i >= 3 + FLT) ? 1'b0 : 1'b1);
    end
    checkVal("ssaLowArb", arbLost, 1'b0);
    ssa = 1'b1;
    cyc(1);
    checkVal("ssaHighSda", sdaLine, 1'b1);
    cyc(3 + FLT);
    checkVal("ssaHighShiftIn", shiftIn, 1'b1);
    checkVal("ssaHighArb", arbLost, 1'b0);

    // shift-out source, StartStopAck held low and ignored
    sel = 1'b1;
    ssa = 1'b0;
    for (int j = 0; j < 4; j++) begin
      so = (j % 2 == 1);
      cyc(1);
      checkVal($sformatf("togSda%0d", j), sdaLine, (j % 2 == 1));
    end
    so = 1'b1;
    cyc(4 + FLT);
    checkVal("togArb", arbLost, 1'b0);
    checkVal("togShiftIn", shiftIn, 1'b1);

    // read mode, external one-cycle pulse
    rw = 1'b1;
    cyc(2);
    extLow = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      checkVal($sformatf("pulseShiftIn%0d", i), shiftIn, (FLT == 0 && i == 2) ? 1'b0 : 1'b1);
      if (i == 1) extLow = 1'b0;
    end

    // read mode, external low held five cycles
    cyc(2);
    extLow = 1'b1;
    for (int i = 1; i <= 8 + FLT; i++) begin
      cyc(1);
      checkVal($sformatf("holdShiftIn%0d", i), shiftIn,
               (i >= 2 + FLT && i <= 6 + FLT) ? 1'b0 : 1'b1);
      if (i == 5) extLow = 1'b0;
    end
    checkVal("holdArb", arbLost, 1'b0);

    // arbitration loss: we release, someone else pulls low
    extLow = 1'b1;
    rw = 1'b0;
    sel = 1'b0;
    ssa = 1'b1;
    for (int i = 1; i <= 5 + FLT; i++) begin
      cyc(1);
      checkVal($sformatf("arbSet%0d", i), arbLost, (i >= 3 + FLT) ? 1'b1 : 1'b0);
    end
    extLow = 1'b0;
    cyc(4 + FLT);
    checkVal("arbSticky", arbLost, 1'b1);
    rw = 1'b1;
    cyc(1);
    checkVal("arbClear", arbLost, 1'b0);

    // asynchronous reset while driving low
    rw = 1'b0;
    sel = 1'b0;
    ssa = 1'b0;
    cyc(4 + FLT);
    checkVal("preRstSda", sdaLine, 1'b0);
    checkVal("preRstShiftIn", shiftIn, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkVal("asyncRstSda", sdaLine, 1'b1);
    checkVal("asyncRstShiftIn", shiftIn, 1'b1);
    checkVal("asyncRstArb", arbLost, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    checkVal("postRstDrive", sdaLine, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
